// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO that feeds a UART transmitter one byte at a time.
// Each byte is popped into para_data with a one-cycle uart_tx_enable pulse,
// then the block waits for tx_done (or a timeout) before the next byte.
module uart_tx_fifo #(
  parameter int DEPTH       = 16,
  parameter int TIMEOUT_CYC = 6000
) (
  input  logic                   uart_clk,
  input  logic                   uart_rst_n,
  input  logic                   wr_en,
  input  logic [7:0]             wr_data,
  input  logic                   tx_done,
  output logic                   uart_tx_enable,
  output logic [7:0]             para_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   busy,
  output logic                   ovf,
  output logic                   tmo
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [TW-1:0] tmo_cnt;
  logic [AW:0]   count_nxt;
  logic          push;
  logic          pop;
  logic          timeout_hit;

  // Writes use the registered full flag, so a drop is decided before any same-edge pop.
  // Pops use the registered empty flag, so a byte written into an empty FIFO waits one edge.
  assign push        = wr_en && !full;
  assign pop         = (state == IDLE) && !empty;
  assign timeout_hit = (state == WAIT) && !tx_done && (tmo_cnt == TMO_LAST);
  assign count_nxt   = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

  assign uart_tx_enable = (state == SEND);
  assign busy           = (state != IDLE);

  // Next-state logic: one start cycle, then wait for tx_done or the timeout.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!empty) state_nxt = SEND;
      SEND:    state_nxt = WAIT;
      WAIT:    if (tx_done || (tmo_cnt == TMO_LAST)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge uart_clk or negedge uart_rst_n) begin
    if (!uart_rst_n) state <= IDLE;
    else             state <= state_nxt;
  end

  // Storage array; contents need no reset because the pointers gate every read.
  always_ff @(posedge uart_clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // Pointers, occupancy flags, popped byte and the sticky overflow flag.
  always_ff @(posedge uart_clk or negedge uart_rst_n) begin
    if (!uart_rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      full      <= 1'b0;
      empty     <= 1'b1;
      para_data <= 8'h00;
      ovf       <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr    <= rd_ptr + 1'b1;
        para_data <= mem[rd_ptr];
      end
      count <= count_nxt;
      full  <= (count_nxt == FULL_CNT);
      empty <= (count_nxt == '0);
      if (wr_en && full) ovf <= 1'b1;
    end
  end

  // Timeout counter, restarted on every start pulse, plus the sticky timeout flag.
  always_ff @(posedge uart_clk or negedge uart_rst_n) begin
    if (!uart_rst_n) begin
      tmo_cnt <= '0;
      tmo     <= 1'b0;
    end else begin
      if (state == SEND) begin
        tmo_cnt <= '0;
      end else if ((state == WAIT) && !tx_done && (tmo_cnt != TMO_LAST)) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
      if (timeout_hit) tmo <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: scoreboard bench for uart_tx_fifo with a queue-based
// reference model and a randomized transmitter responder.
module tb_uart_tx_fifo;

  localparam int DEPTH = 16;
  localparam int TMO   = 40;

  logic       uart_clk   = 1'b0;
  logic       uart_rst_n = 1'b0;
  logic       wr_en      = 1'b0;
  logic [7:0] wr_data    = 8'h00;
  logic       tx_done    = 1'b0;
  logic       uart_tx_enable;
  logic [7:0] para_data;
  logic       full;
  logic       empty;
  logic [4:0] count;
  logic       busy;
  logic       ovf;
  logic       tmo;

  uart_tx_fifo #(.DEPTH(DEPTH), .TIMEOUT_CYC(TMO)) dut (
    .uart_clk       (uart_clk),
    .uart_rst_n     (uart_rst_n),
    .wr_en          (wr_en),
    .wr_data        (wr_data),
    .tx_done        (tx_done),
    .uart_tx_enable (uart_tx_enable),
    .para_data      (para_data),
    .full           (full),
    .empty          (empty),
    .count          (count),
    .busy           (busy),
    .ovf            (ovf),
    .tmo            (tmo)
  );

  // 100 MHz clock.
  always #5 uart_clk = ~uart_clk;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] sb[$];
  int         model_count = 0;
  bit         ovf_exp = 0;
  bit         tmo_exp = 0;
  logic [7:0] last_byte = 8'h00;
  bit         prev_en = 0;
  bit         prev_busy = 0;
  logic [7:0] mon_exp;
  int         rsp_mode = 0;
  int         rsp_min = 1;
  int         rsp_max = 8;
  int         rsp_cur_mode;
  int         rsp_delay;
  bit         rsp_spur;

  function automatic void check_output(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Scoreboard monitor: each start pulse pops one expected byte; flags follow the model.
  always @(negedge uart_clk) begin
    if (uart_rst_n) begin
      if (uart_tx_enable) begin
        check_output("en_width", int'(prev_en), 0);
        check_output("idle_gap", int'(prev_busy), 0);
        check_output("byte_expected", int'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          mon_exp = sb.pop_front();
          check_output("para_data", para_data, mon_exp);
          last_byte = mon_exp;
        end
        model_count--;
      end else begin
        check_output("para_hold", para_data, last_byte);
      end
      check_output("count", count, model_count);
      check_output("full", full, int'(model_count == DEPTH));
      check_output("empty", empty, int'(model_count == 0));
      check_output("ovf", ovf, int'(ovf_exp));
      check_output("tmo", tmo, int'(tmo_exp));
      prev_en   = uart_tx_enable;
      prev_busy = busy;
    end
  end

  // Transmitter responder: mode 0 answers after a random delay, 1 withholds to force a timeout, 2 stays silent.
  always begin
    @(negedge uart_clk);
    if (uart_rst_n && uart_tx_enable) begin
      rsp_cur_mode = rsp_mode;
      rsp_mode     = 0;
      if (rsp_cur_mode == 0) begin
        rsp_spur  = ($urandom_range(0, 3) == 0);
        rsp_delay = $urandom_range(rsp_min, rsp_max);
        tx_done   = rsp_spur;
        @(posedge uart_clk); #1;
        check_output("send_exit_busy", busy, 1);
        tx_done = 1'b0;
        repeat (rsp_delay - 1) @(posedge uart_clk);
        @(negedge uart_clk);
        tx_done = 1'b1;
        @(posedge uart_clk); #1;
        tx_done = 1'b0;
        check_output("done_busy", busy, 0);
      end else if (rsp_cur_mode == 1) begin
        @(posedge uart_clk); #1;
        check_output("wait_busy", busy, 1);
        repeat (TMO - 1) @(posedge uart_clk);
        #1;
        check_output("pre_tmo_busy", busy, 1);
        check_output("pre_tmo_flag", tmo, int'(tmo_exp));
        @(posedge uart_clk); #1;
        check_output("tmo_busy", busy, 0);
        check_output("tmo_flag", tmo, 1);
        tmo_exp = 1'b1;
      end
    end
  end

  task automatic drive_now(bit en, logic [7:0] d);
    wr_en   = en;
    wr_data = d;
    if (en) begin
      if (model_count >= DEPTH) begin
        ovf_exp = 1'b1;
      end else begin
        sb.push_back(d);
        model_count++;
      end
    end
  endtask

  task automatic write_cycle(bit en, logic [7:0] d);
    @(negedge uart_clk); #1;
    drive_now(en, d);
  endtask

  task automatic apply_reset();
    @(negedge uart_clk); #2;
    uart_rst_n = 1'b0;
    wr_en      = 1'b0;
    tx_done    = 1'b0;
    #1;
    check_output("rst_en", uart_tx_enable, 0);
    check_output("rst_busy", busy, 0);
    check_output("rst_data", para_data, 8'h00);
    check_output("rst_count", count, 0);
    check_output("rst_empty", empty, 1);
    check_output("rst_full", full, 0);
    check_output("rst_ovf", ovf, 0);
    check_output("rst_tmo", tmo, 0);
    sb.delete();
    model_count = 0;
    ovf_exp     = 1'b0;
    tmo_exp     = 1'b0;
    last_byte   = 8'h00;
    prev_en     = 1'b0;
    prev_busy   = 1'b0;
    repeat (2) @(negedge uart_clk);
    #2 uart_rst_n = 1'b1;
  endtask

  task automatic wait_idle(int limit);
    bit done = 0;
    for (int i = 0; i < limit && !done; i++) begin
      @(negedge uart_clk); #1;
      if (!busy && empty && (sb.size() == 0)) done = 1;
    end
    check_output("drain_done", int'(done), 1);
  endtask

  // Simulation watchdog.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main stimulus sequence.
  initial begin
    logic [7:0] hello [13];
    int guard;
    int en_seen;
    hello = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h20, 8'h57,
              8'h6F, 8'h72, 8'h6C, 8'h64, 8'h21, 8'h0A};

    apply_reset();

    // Single byte latency into an idle, empty FIFO.
    rsp_min = 5; rsp_max = 5;
    write_cycle(1'b1, 8'h48);
    write_cycle(1'b0, 8'h00);
    check_output("lat_k_en", uart_tx_enable, 0);
    check_output("lat_k_empty", empty, 0);
    @(negedge uart_clk); #1;
    check_output("lat_en", uart_tx_enable, 1);
    check_output("lat_data", para_data, 8'h48);
    check_output("lat_busy", busy, 1);
    wait_idle(200);

    // Burst of a text line with a fixed transmitter time.
    rsp_min = 20; rsp_max = 20;
    for (int i = 0; i < 13; i++) write_cycle(1'b1, hello[i]);
    write_cycle(1'b0, 8'h00);
    wait_idle(1000);

    // Overfill: the first byte is popped, sixteen fill the FIFO, the last is dropped.
    rsp_min = 30; rsp_max = 30;
    for (int i = 0; i < 18; i++) write_cycle(1'b1, 8'hA0 + 8'(i));
    write_cycle(1'b0, 8'h00);
    check_output("ovfl_full", full, 1);
    check_output("ovfl_count", count, 16);
    check_output("ovfl_flag", ovf, 1);
    wait_idle(2000);

    // Timeout on one byte, then the next queued byte still goes out.
    rsp_min = 6; rsp_max = 6;
    rsp_mode = 1;
    write_cycle(1'b1, 8'h55);
    write_cycle(1'b1, 8'h66);
    write_cycle(1'b0, 8'h00);
    wait_idle(500);
    check_output("tmo_after", tmo, 1);

    // Simultaneous write and pop at count 5.
    rsp_min = 12; rsp_max = 12;
    for (int i = 0; i < 6; i++) write_cycle(1'b1, 8'h10 + 8'(i));
    write_cycle(1'b0, 8'h00);
    guard = 0;
    while (busy && guard < 50) begin
      @(negedge uart_clk); #1;
      guard++;
    end
    check_output("c5_idle", busy, 0);
    check_output("c5_pre", count, 5);
    drive_now(1'b1, 8'h77);
    write_cycle(1'b0, 8'h00);
    check_output("c5_same", count, 5);
    check_output("c5_en", uart_tx_enable, 1);
    wait_idle(1000);

    // Reset while waiting on the transmitter with four bytes queued.
    rsp_mode = 2;
    for (int i = 0; i < 5; i++) write_cycle(1'b1, 8'hC0 + 8'(i));
    write_cycle(1'b0, 8'h00);
    repeat (6) @(negedge uart_clk);
    #1;
    check_output("pre_rst_count", count, 4);
    check_output("pre_rst_busy", busy, 1);
    apply_reset();
    en_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge uart_clk); #1;
      if (uart_tx_enable) en_seen++;
    end
    check_output("post_rst_no_en", en_seen, 0);
    rsp_min = 4; rsp_max = 4;
    write_cycle(1'b1, 8'h3C);
    write_cycle(1'b0, 8'h00);
    wait_idle(200);

    // Randomized traffic with random transmitter delays and occasional timeouts.
    rsp_min = 1; rsp_max = 15;
    for (int i = 0; i < 400; i++) begin
      if (rsp_mode == 0 && $urandom_range(0, 149) == 0) rsp_mode = 1;
      write_cycle($urandom_range(0, 9) < 3, 8'($urandom));
    end
    write_cycle(1'b0, 8'h00);
    wait_idle(3000);
    check_output("sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
